// File: rtl/regfile_pkg.sv
// Shared defaults, address/counter types and reset-value helper for the
// scoreboarded register file.
package regfile_pkg;
  localparam int DEF_WIDTH    = 64;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_ZERO_REG = 31;
  localparam int DEF_MAXPEND  = 3;
  localparam int DEF_AW       = $clog2(DEF_DEPTH);
  localparam int DEF_PCW      = $clog2(DEF_MAXPEND + 1);

  typedef logic [DEF_AW-1:0]  reg_addr_t;
  typedef logic [DEF_PCW-1:0] pend_cnt_t;

  function automatic logic [DEF_WIDTH-1:0] rf_init(input int unsigned i, input bit init_idx);
    return init_idx ? DEF_WIDTH'(i) : '0;
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: write port, read ports, issue handshake, error flag.
interface regfile_sb_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
) ();
  localparam int AW = $clog2(DEPTH);

  logic                        we3;
  logic [AW-1:0]               wa3;
  logic [WIDTH-1:0]            wd3;
  logic [NREAD-1:0][AW-1:0]    ra;
  logic [NREAD-1:0][WIDTH-1:0] rd;
  logic [NREAD-1:0]            rbusy;
  logic                        issue_valid;
  logic [AW-1:0]               issue_dst;
  logic                        issue_ready;
  logic                        err_uflow;

  modport master (
    output we3, wa3, wd3, ra, issue_valid, issue_dst,
    input  rd, rbusy, issue_ready, err_uflow
  );
  modport slave (
    input  we3, wa3, wd3, ra, issue_valid, issue_dst,
    output rd, rbusy, issue_ready, err_uflow
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters: issue admission, per-port busy lookup
// and sticky underflow flag.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int MAXPEND  = DEF_MAXPEND,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int NREAD    = DEF_NREAD,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int PCW     = $clog2(MAXPEND + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [AW-1:0]            wa_i,
  input  logic                     issue_valid_i,
  input  logic [AW-1:0]            issue_dst_i,
  input  logic [NREAD-1:0][AW-1:0] ra_i,
  output logic                     issue_ready_o,
  output logic [NREAD-1:0]         rbusy_o,
  output logic                     err_uflow_o
);
  logic [DEPTH-1:0][PCW-1:0] pend_q, pend_d;
  logic                      err_q, err_d;
  logic [PCW-1:0]            dst_pend, wa_pend;
  logic                      wr_hit, inc, dec;

  function automatic logic is_reg(input logic [AW-1:0] a);
    return (a != AW'(ZERO_REG)) && (32'(a) < DEPTH);
  endfunction

  assign dst_pend = is_reg(issue_dst_i) ? pend_q[issue_dst_i] : '0;
  assign wa_pend  = is_reg(wa_i) ? pend_q[wa_i] : '0;
  assign wr_hit   = we_i && is_reg(wa_i);

  // A retirement to the same register frees its slot in the cycle it lands.
  assign issue_ready_o = !is_reg(issue_dst_i) || (dst_pend < PCW'(MAXPEND)) ||
                         (we_i && (wa_i == issue_dst_i));
  assign inc = issue_valid_i && issue_ready_o && is_reg(issue_dst_i);
  assign dec = wr_hit && (wa_pend != '0);

  always_comb begin
    pend_d = pend_q;
    if (!(inc && dec && (issue_dst_i == wa_i))) begin
      if (inc) pend_d[issue_dst_i] = pend_q[issue_dst_i] + PCW'(1);
      if (dec) pend_d[wa_i]        = pend_q[wa_i] - PCW'(1);
    end
  end

  assign err_d = err_q | (wr_hit && (wa_pend == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign err_uflow_o = err_q;

  for (genvar g = 0; g < NREAD; g++) begin : g_busy
    logic [AW-1:0]  a;
    logic [PCW-1:0] p;
    logic           own;
    assign a   = ra_i[g];
    assign p   = is_reg(a) ? pend_q[a] : '0;
    // With forwarding, the write landing this cycle satisfies one pending entry.
    assign own = (BYPASS != 0) && we_i && (wa_i == a);
    assign rbusy_o[g] = p > PCW'(own);
  end
endmodule

// File: rtl/regfile_sb.sv
// Register file with NREAD async read ports, one write port, zero register,
// optional write->read forwarding and an integrated RAW scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = 1,
  parameter int MAXPEND  = DEF_MAXPEND,
  parameter int INIT_IDX = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q;
  logic                        wr_en;

  assign wr_en = bus.we3 && (bus.wa3 != AW'(ZERO_REG)) && (32'(bus.wa3) < DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= (i == ZERO_REG) ? '0 : WIDTH'(rf_init(i, INIT_IDX != 0));
    end else if (wr_en) begin
      regs_q[bus.wa3] <= bus.wd3;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          valid_a, fwd;
    assign a       = bus.ra[g];
    assign valid_a = (a != AW'(ZERO_REG)) && (32'(a) < DEPTH);
    assign fwd     = (BYPASS != 0) && bus.we3 && (bus.wa3 == a);
    assign bus.rd[g] = !valid_a ? '0 : (fwd ? bus.wd3 : regs_q[a]);
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .MAXPEND (MAXPEND),
    .ZERO_REG(ZERO_REG),
    .NREAD   (NREAD),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (bus.we3),
    .wa_i         (bus.wa3),
    .issue_valid_i(bus.issue_valid),
    .issue_dst_i  (bus.issue_dst),
    .ra_i         (bus.ra),
    .issue_ready_o(bus.issue_ready),
    .rbusy_o      (bus.rbusy),
    .err_uflow_o  (bus.err_uflow)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: driver pushes model expectations, monitor compares both
// BYPASS=1 and BYPASS=0 instances every negedge.
module tb_regfile_sb;
  localparam int W = 64, D = 32, NR = 2, AW = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_we = 1'b0, s_iv = 1'b0;
  logic [AW-1:0] s_wa = '0, s_dst = '0, s_ra0 = '0, s_ra1 = '0;
  logic [W-1:0]  s_wd = '0;

  regfile_sb_if #(.WIDTH(W), .DEPTH(D), .NREAD(NR)) bb ();
  regfile_sb_if #(.WIDTH(W), .DEPTH(D), .NREAD(NR)) bn ();

  assign bb.we3 = s_we;  assign bb.wa3 = s_wa;  assign bb.wd3 = s_wd;
  assign bb.ra = {s_ra1, s_ra0};  assign bb.issue_valid = s_iv;  assign bb.issue_dst = s_dst;
  assign bn.we3 = s_we;  assign bn.wa3 = s_wa;  assign bn.wd3 = s_wd;
  assign bn.ra = {s_ra1, s_ra0};  assign bn.issue_valid = s_iv;  assign bn.issue_dst = s_dst;

  regfile_sb #(.BYPASS(1)) u_byp (.clk(clk), .rst_n(rst_n), .bus(bb));
  regfile_sb #(.BYPASS(0)) u_nob (.clk(clk), .rst_n(rst_n), .bus(bn));

  typedef struct {
    logic [63:0] rdb0, rdb1, rdn0, rdn1;
    logic [1:0]  bsb, bsn;
    logic        rdy, err;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0;
  logic [63:0] m_reg [D];
  int          m_pend [D];
  bit          m_err;
  int          hot [5] = '{4, 7, 9, 12, 31};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit m_isreg(input int a);
    return (a != 31) && (a < D);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) begin
      m_reg[i]  = (i == 31) ? 64'd0 : 64'(i);
      m_pend[i] = 0;
    end
    m_err = 0;
  endtask

  function automatic logic [63:0] m_read(input int a, input bit byp);
    if (!m_isreg(a)) return 64'd0;
    if (byp && s_we && int'(s_wa) == a) return s_wd;
    return m_reg[a];
  endfunction

  function automatic bit m_busy(input int a, input bit byp);
    if (!m_isreg(a)) return 0;
    return m_pend[a] > ((byp && s_we && int'(s_wa) == a) ? 1 : 0);
  endfunction

  function automatic bit m_ready(input int dst);
    return !m_isreg(dst) || m_pend[dst] < 3 || (s_we && int'(s_wa) == dst);
  endfunction

  task automatic drive(input bit rst, input bit we, input int wa, input logic [63:0] wd,
                       input int ra0, input int ra1, input bit iv, input int dst);
    exp_t e;
    bit inc, dec;
    @(posedge clk); #1;
    s_we = we; s_wa = AW'(wa); s_wd = wd; s_ra0 = AW'(ra0); s_ra1 = AW'(ra1);
    s_iv = iv; s_dst = AW'(dst);
    rst_n = rst;
    if (!rst) m_reset();
    e.rdb0 = m_read(ra0, 1);  e.rdb1 = m_read(ra1, 1);
    e.rdn0 = m_read(ra0, 0);  e.rdn1 = m_read(ra1, 0);
    e.bsb  = {m_busy(ra1, 1), m_busy(ra0, 1)};
    e.bsn  = {m_busy(ra1, 0), m_busy(ra0, 0)};
    e.rdy  = m_ready(dst);
    e.err  = m_err;
    q.push_back(e);
    if (rst) begin
      inc = iv && e.rdy && m_isreg(dst);
      dec = we && m_isreg(wa) && m_pend[wa] != 0;
      if (we && m_isreg(wa)) begin
        m_reg[wa] = wd;
        if (m_pend[wa] == 0) m_err = 1;
      end
      if (inc) m_pend[dst]++;
      if (dec) m_pend[wa]--;
    end
  endtask

  function automatic int pick();
    if ($urandom_range(0, 1) == 1) return hot[$urandom_range(0, 4)];
    return int'($urandom_range(0, 31));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd0_byp",  bb.rd[0], e.rdb0);
        chk("rd1_byp",  bb.rd[1], e.rdb1);
        chk("rd0_nob",  bn.rd[0], e.rdn0);
        chk("rd1_nob",  bn.rd[1], e.rdn1);
        chk("rbusy_byp", 64'(bb.rbusy), 64'(e.bsb));
        chk("rbusy_nob", 64'(bn.rbusy), 64'(e.bsn));
        chk("ready_byp", 64'(bb.issue_ready), 64'(e.rdy));
        chk("ready_nob", 64'(bn.issue_ready), 64'(e.rdy));
        chk("uflow_byp", 64'(bb.err_uflow), 64'(e.err));
        chk("uflow_nob", 64'(bn.err_uflow), 64'(e.err));
      end
    end
  end

  initial begin : driver
    int cand[$];
    int wa;
    m_reset();
    // reset state and zero register
    drive(0, 0, 0, 0, 5, 31, 0, 0);
    drive(1, 0, 0, 0, 5, 31, 0, 0);
    // same-cycle forwarding vs. next-cycle visibility
    drive(1, 1, 7, 64'hDEAD, 7, 5, 0, 0);
    drive(1, 0, 0, 0, 7, 7, 0, 0);
    // zero register ignores writes and issues
    drive(1, 1, 31, 64'hFF, 31, 31, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 31, 31, 1, 31);
    // saturation at MAXPEND, retire frees slot same cycle
    repeat (3) drive(1, 0, 0, 0, 4, 31, 1, 4);
    drive(1, 1, 4, 64'h44, 4, 31, 1, 4);
    drive(1, 0, 0, 0, 4, 31, 1, 4);
    // RAW hazard cleared by writeback
    drive(1, 0, 0, 0, 9, 31, 1, 9);
    drive(1, 1, 9, 64'h99, 9, 31, 0, 0);
    drive(1, 0, 0, 0, 9, 31, 0, 0);
    // underflow, then reset mid-burst, then stale writeback after reset
    drive(1, 1, 12, 64'h1212, 12, 4, 0, 0);
    drive(1, 1, 4, 64'h4, 4, 12, 1, 4);
    drive(0, 1, 4, 64'h5, 4, 12, 1, 4);
    drive(1, 0, 0, 0, 4, 12, 0, 0);
    drive(1, 1, 4, 64'h6, 4, 12, 0, 0);
    drive(1, 0, 0, 0, 4, 12, 0, 0);

    for (int c = 0; c < 800; c++) begin
      cand.delete();
      for (int r = 0; r < D; r++) if (m_pend[r] > 0) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 4) != 0)
        wa = cand[$urandom_range(0, cand.size() - 1)];
      else
        wa = pick();
      drive($urandom_range(0, 149) != 0, $urandom_range(0, 9) < 4, wa,
            {$urandom, $urandom}, pick(), pick(), $urandom_range(0, 1) == 1, pick());
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
